grf_scoreboard: RTL and testbench

- Register-file hazard scheduler for the 5-stage pipeline; sits beside the GRF at the decode stage.
- Tracks, per architectural register, whether a write is still in flight and how many cycles remain until its result is forwardable (Tnew).
- Compares these against the decode-stage source operands' Tuse, then issues stall or forward-required indications.
- Keeps a free-running count of stall cycles for performance checks.

---
 rtl/grf_scoreboard.sv | 89 ++++++++
 tb/tb_grf_scoreboard.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/grf_scoreboard.sv
// rtl/grf_scoreboard.sv - decode-stage GRF hazard scoreboard with stall/forward flags and stall counter
module grf_scoreboard #(
    parameter int NREG = 32,
    parameter int TW   = 2,
    parameter int SCW  = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            issue_valid,
    input  logic [4:0]      issue_wa,
    input  logic [TW-1:0]   issue_tnew,
    input  logic [4:0]      rs_a,
    input  logic [TW-1:0]   rs_tuse,
    input  logic [4:0]      rt_a,
    input  logic [TW-1:0]   rt_tuse,
    input  logic            wb_valid,
    input  logic [4:0]      wb_wa,
    output logic            stall,
    output logic            rs_fwd,
    output logic            rt_fwd,
    output logic [NREG-1:0] busy_vec,
    output logic [SCW-1:0]  stall_cycles
);

    // Per-register in-flight state: busy flag plus cycles until forwardable.
    logic [NREG-1:0] r_busy;
    logic [TW-1:0]   r_cnt [NREG];
    logic [SCW-1:0]  r_stall_cycles;

    logic w_rs_pend;
    logic w_rt_pend;
    logic w_haz_rs;
    logic w_haz_rt;
    logic w_stall;
    logic w_issue_accept;

    // Operand is pending when its producer is still in flight; register 0 never is.
    assign w_rs_pend = (rs_a != 5'd0) & r_busy[rs_a];
    assign w_rt_pend = (rt_a != 5'd0) & r_busy[rt_a];

    // Hazard only when the result arrives later than the operand is needed.
    // A writeback in this same cycle is deliberately ignored: decode cannot see it yet.
    assign w_haz_rs = w_rs_pend & (r_cnt[rs_a] > rs_tuse);
    assign w_haz_rt = w_rt_pend & (r_cnt[rt_a] > rt_tuse);
    assign w_stall  = w_haz_rs | w_haz_rt;

    // A stalled instruction is not issued; writes to register 0 are never tracked.
    assign w_issue_accept = issue_valid & ~w_stall & (issue_wa != 5'd0);

    assign stall        = w_stall;
    assign rs_fwd       = w_rs_pend & ~w_haz_rs;
    assign rt_fwd       = w_rt_pend & ~w_haz_rt;
    assign busy_vec     = r_busy;
    assign stall_cycles = r_stall_cycles;

    // Entry update: newest issue beats writeback, writeback beats countdown; cnt saturates at 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_busy[i] <= 1'b0;
                r_cnt[i]  <= '0;
            end
        end else begin
            r_busy[0] <= 1'b0;
            r_cnt[0]  <= '0;
            for (int i = 1; i < NREG; i++) begin
                if (w_issue_accept && (issue_wa == 5'(i))) begin
                    r_busy[i] <= 1'b1;
                    r_cnt[i]  <= issue_tnew;
                end else if (wb_valid && (wb_wa == 5'(i))) begin
                    r_busy[i] <= 1'b0;
                    r_cnt[i]  <= '0;
                end else if (r_busy[i] && (r_cnt[i] != '0)) begin
                    r_cnt[i]  <= r_cnt[i] - TW'(1);
                end
            end
        end
    end

    // Free-running count of bubble cycles, wrapping naturally at 2^SCW.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cycles <= '0;
        end else if (w_stall) begin
            r_stall_cycles <= r_stall_cycles + SCW'(1);
        end
    end

endmodule

// File: tb/tb_grf_scoreboard.sv
// tb/tb_grf_scoreboard.sv - self-checking bench for grf_scoreboard with a behavioural reference model
module tb_grf_scoreboard;

    logic        clk;
    logic        reset;
    logic        issue_valid;
    logic [4:0]  issue_wa;
    logic [1:0]  issue_tnew;
    logic [4:0]  rs_a;
    logic [1:0]  rs_tuse;
    logic [4:0]  rt_a;
    logic [1:0]  rt_tuse;
    logic        wb_valid;
    logic [4:0]  wb_wa;
    logic        stall;
    logic        rs_fwd;
    logic        rt_fwd;
    logic [31:0] busy_vec;
    logic [31:0] stall_cycles;

    int checks;
    int errors;

    // Reference model: how many cycles each register's pending result is still away.
    bit          m_busy [32];
    int          m_cnt  [32];
    logic [31:0] m_sc;

    grf_scoreboard #(.NREG(32), .TW(2), .SCW(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_wa    (issue_wa),
        .issue_tnew  (issue_tnew),
        .rs_a        (rs_a),
        .rs_tuse     (rs_tuse),
        .rt_a        (rt_a),
        .rt_tuse     (rt_tuse),
        .wb_valid    (wb_valid),
        .wb_wa       (wb_wa),
        .stall       (stall),
        .rs_fwd      (rs_fwd),
        .rt_fwd      (rt_fwd),
        .busy_vec    (busy_vec),
        .stall_cycles(stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit m_haz(int a, int tuse);
        return (a != 0) && m_busy[a] && (m_cnt[a] > tuse);
    endfunction

    function automatic bit m_fwd(int a, int tuse);
        return (a != 0) && m_busy[a] && !m_haz(a, tuse);
    endfunction

    function automatic bit m_stall();
        return m_haz(int'(rs_a), int'(rs_tuse)) || m_haz(int'(rt_a), int'(rt_tuse));
    endfunction

    function automatic logic [31:0] m_busy_vec();
        logic [31:0] v;
        v = '0;
        for (int i = 1; i < 32; i++) v[i] = m_busy[i];
        return v;
    endfunction

    task automatic idle();
        reset = 1'b0; issue_valid = 1'b0; issue_wa = '0; issue_tnew = '0;
        rs_a = '0; rs_tuse = '0; rt_a = '0; rt_tuse = '0; wb_valid = 1'b0; wb_wa = '0;
    endtask

    // Advance one clock and apply the architectural rules to the model.
    task automatic tick();
        bit st;
        bit acc;
        st  = m_stall();
        acc = issue_valid && !st && (issue_wa != 0);
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 32; i++) begin m_busy[i] = 0; m_cnt[i] = 0; end
            m_sc = '0;
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (acc && int'(issue_wa) == i) begin
                    m_busy[i] = 1; m_cnt[i] = int'(issue_tnew);
                end else if (wb_valid && int'(wb_wa) == i) begin
                    m_busy[i] = 0; m_cnt[i] = 0;
                end else if (m_busy[i] && m_cnt[i] > 0) begin
                    m_cnt[i] = m_cnt[i] - 1;
                end
            end
            if (st) m_sc = m_sc + 32'd1;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        idle(); reset = 1'b1; tick(); reset = 1'b0;
        rs_a = 5'd5; rt_a = 5'd6; #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b want 0", stall); end
        checks++; if (rs_fwd !== 1'b0) begin errors++; $display("FAIL rst_rs_fwd: got %b want 0", rs_fwd); end
        checks++; if (rt_fwd !== 1'b0) begin errors++; $display("FAIL rst_rt_fwd: got %b want 0", rt_fwd); end
        checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL rst_busy: got %h want 0", busy_vec); end
        checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL rst_sc: got %0d want 0", stall_cycles); end
    endtask

    task automatic test_countdown();
        idle(); issue_valid = 1'b1; issue_wa = 5'd8; issue_tnew = 2'd2; tick();
        idle(); rs_a = 5'd8; rs_tuse = 2'd0; #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL cd_stall_c2: got %b want 1", stall); end
        tick(); #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL cd_stall_c1: got %b want 1", stall); end
        tick(); #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL cd_stall_c0: got %b want 0", stall); end
        checks++; if (rs_fwd !== 1'b1) begin errors++; $display("FAIL cd_rs_fwd: got %b want 1", rs_fwd); end
        checks++; if (stall_cycles !== 32'd2) begin errors++; $display("FAIL cd_sc: got %0d want 2", stall_cycles); end
        idle(); wb_valid = 1'b1; wb_wa = 5'd8; tick(); idle(); #1;
        checks++; if (busy_vec[8] !== 1'b0) begin errors++; $display("FAIL cd_wb_clear: got %b want 0", busy_vec[8]); end
    endtask

    task automatic test_issue_vs_wb();
        idle(); issue_valid = 1'b1; issue_wa = 5'd8; issue_tnew = 2'd1;
        wb_valid = 1'b1; wb_wa = 5'd8; tick();
        idle(); rs_a = 5'd8; rs_tuse = 2'd0; #1;
        checks++; if (busy_vec[8] !== 1'b1) begin errors++; $display("FAIL iw_busy: got %b want 1", busy_vec[8]); end
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL iw_cnt1_stall: got %b want 1", stall); end
        rs_tuse = 2'd1; #1;
        checks++; if (rs_fwd !== 1'b1) begin errors++; $display("FAIL iw_cnt1_fwd: got %b want 1", rs_fwd); end
        idle(); wb_valid = 1'b1; wb_wa = 5'd8; tick(); idle();
    endtask

    task automatic test_wa_zero();
        idle(); issue_valid = 1'b1; issue_wa = 5'd0; issue_tnew = 2'd3; tick();
        idle(); #1;
        checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL wz_busy: got %h want 0", busy_vec); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL wz_stall: got %b want 0", stall); end
        checks++; if (rs_fwd !== 1'b0) begin errors++; $display("FAIL wz_rs_fwd: got %b want 0", rs_fwd); end
    endtask

    task automatic test_blocked_issue();
        idle(); issue_valid = 1'b1; issue_wa = 5'd9; issue_tnew = 2'd3; tick();
        issue_wa = 5'd10; issue_tnew = 2'd1; rt_a = 5'd9; rt_tuse = 2'd1; #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL bi_stall_a: got %b want 1", stall); end
        tick(); #1;
        checks++; if (busy_vec[10] !== 1'b0) begin errors++; $display("FAIL bi_busy10_a: got %b want 0", busy_vec[10]); end
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL bi_stall_b: got %b want 1", stall); end
        tick(); #1;
        checks++; if (busy_vec[10] !== 1'b0) begin errors++; $display("FAIL bi_busy10_b: got %b want 0", busy_vec[10]); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL bi_release: got %b want 0", stall); end
        checks++; if (rt_fwd !== 1'b1) begin errors++; $display("FAIL bi_rt_fwd: got %b want 1", rt_fwd); end
        tick(); idle(); #1;
        checks++; if (busy_vec[10] !== 1'b1) begin errors++; $display("FAIL bi_busy10_set: got %b want 1", busy_vec[10]); end
        wb_valid = 1'b1; wb_wa = 5'd9; tick(); wb_wa = 5'd10; tick(); idle();
    endtask

    task automatic test_back_to_back();
        idle(); issue_valid = 1'b1; issue_wa = 5'd4; issue_tnew = 2'd3; tick();
        issue_tnew = 2'd0; tick();
        idle(); rs_a = 5'd4; rs_tuse = 2'd0; #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b2b_stall: got %b want 0", stall); end
        checks++; if (rs_fwd !== 1'b1) begin errors++; $display("FAIL b2b_rs_fwd: got %b want 1", rs_fwd); end
        idle(); wb_valid = 1'b1; wb_wa = 5'd4; tick(); idle();
    endtask

    task automatic test_reset_mid();
        idle(); issue_valid = 1'b1; issue_wa = 5'd3; issue_tnew = 2'd3; tick();
        idle(); rs_a = 5'd3; #1;
        checks++; if (busy_vec[3] !== 1'b1) begin errors++; $display("FAIL rm_busy3: got %b want 1", busy_vec[3]); end
        tick();
        reset = 1'b1; tick(); reset = 1'b0; #1;
        checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL rm_busy: got %h want 0", busy_vec); end
        checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL rm_sc: got %0d want 0", stall_cycles); end
        idle();
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            reset       = ($urandom_range(0, 149) == 0);
            issue_valid = $urandom_range(0, 1) == 1;
            issue_wa    = 5'($urandom_range(0, 7));
            issue_tnew  = 2'($urandom_range(0, 3));
            rs_a        = 5'($urandom_range(0, 7));
            rs_tuse     = 2'($urandom_range(0, 3));
            rt_a        = 5'($urandom_range(0, 7));
            rt_tuse     = 2'($urandom_range(0, 3));
            wb_valid    = $urandom_range(0, 2) == 0;
            wb_wa       = 5'($urandom_range(0, 7));
            #1;
            checks++; if (stall !== m_stall()) begin errors++; $display("FAIL rnd_stall n=%0d: got %b want %b", n, stall, m_stall()); end
            checks++; if (rs_fwd !== m_fwd(int'(rs_a), int'(rs_tuse))) begin errors++; $display("FAIL rnd_rs_fwd n=%0d: got %b want %b", n, rs_fwd, m_fwd(int'(rs_a), int'(rs_tuse))); end
            checks++; if (rt_fwd !== m_fwd(int'(rt_a), int'(rt_tuse))) begin errors++; $display("FAIL rnd_rt_fwd n=%0d: got %b want %b", n, rt_fwd, m_fwd(int'(rt_a), int'(rt_tuse))); end
            checks++; if (busy_vec !== m_busy_vec()) begin errors++; $display("FAIL rnd_busy n=%0d: got %h want %h", n, busy_vec, m_busy_vec()); end
            checks++; if (stall_cycles !== m_sc) begin errors++; $display("FAIL rnd_sc n=%0d: got %0d want %0d", n, stall_cycles, m_sc); end
            tick();
        end
        idle();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        m_sc   = '0;
        for (int i = 0; i < 32; i++) begin m_busy[i] = 0; m_cnt[i] = 0; end
        idle();
        @(negedge clk);
        test_reset();
        test_countdown();
        test_issue_vs_wb();
        test_wa_zero();
        test_blocked_issue();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
